// File: rtl/hyper_clk_phase_gen_if.sv
// Divider configuration handshake between a controller and hyper_clk_phase_gen.
// The master offers a new divide setting; the slave reports when it can take one.
interface hyper_clk_phase_gen_if #(
    parameter int unsigned DivWidth = 8
);
    logic                cfg_valid_i;
    logic                cfg_ready_o;
    logic [DivWidth-1:0] cfg_div_i;

    modport master (
        output cfg_valid_i,
        output cfg_div_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_div_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/hyper_clk_phase_gen.sv
// Programmable 4-phase clock generator: divides clk_i by 4*D into 0/90/180/270 degree
// clocks, with glitch-free divider changes at period boundaries and clean start/stop.
module hyper_clk_phase_gen #(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    hyper_clk_phase_gen_if.slave cfg_if,
    output logic                 clk0_o,
    output logic                 clk90_o,
    output logic                 clk180_o,
    output logic                 clk270_o,
    output logic                 running_o,
    output logic                 period_start_o,
    output logic [DivWidth-1:0]  div_o
);
    localparam int unsigned CntWidth = DivWidth + 2;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [DivWidth-1:0] div_pend_q, div_pend_d;
    logic [DivWidth-1:0] tail_q, tail_d;
    logic                pend_q, pend_d;
    logic [3:0]          clk_q, clk_d;
    logic                start_q, start_d;
    logic                running_q, running_d;
    logic                ready_q, ready_d;

    logic [CntWidth-1:0] div_ext, div_n, tail_n;
    logic                period_last, drain_last, xfer;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        tail_d     = tail_q;
        pend_d     = pend_q;
        clk_d      = '0;
        start_d    = 1'b0;
        running_d  = 1'b0;

        div_ext     = CntWidth'(div_q);
        period_last = (cnt_q == ((div_ext << 2) - CntWidth'(1)));
        drain_last  = (cnt_q == (div_ext - CntWidth'(1)));
        xfer        = cfg_if.cfg_valid_i & ~pend_q;

        // tail_d: how long clk270 stays high at the start of the next segment,
        // i.e. the remainder of the previous period's 270-degree pulse (0 on start).
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = div_pend_q;
                    pend_d = 1'b0;
                end
                if (en_i) begin
                    state_d = StRun;
                    tail_d  = '0;
                end
            end
            StRun: begin
                if (period_last) begin
                    cnt_d  = '0;
                    tail_d = div_q;
                    if (en_i) begin
                        if (pend_q) begin
                            div_d  = div_pend_q;
                            pend_d = 1'b0;
                        end
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StDrain: begin
                if (drain_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (xfer) begin
            pend_d     = 1'b1;
            div_pend_d = (cfg_if.cfg_div_i == '0) ? DivWidth'(1) : cfg_if.cfg_div_i;
        end

        // Output flops are loaded from next-state values so they line up with cnt_q.
        div_n  = CntWidth'(div_d);
        tail_n = CntWidth'(tail_d);
        if (state_d == StRun) begin
            clk_d[0]  = (cnt_d < (div_n << 1));
            clk_d[1]  = (cnt_d >= div_n) && (cnt_d < (div_n + (div_n << 1)));
            clk_d[2]  = (cnt_d >= (div_n << 1));
            clk_d[3]  = (cnt_d >= (div_n + (div_n << 1))) || (cnt_d < tail_n);
            start_d   = (cnt_d == '0);
            running_d = 1'b1;
        end else if (state_d == StDrain) begin
            clk_d[3]  = (cnt_d < tail_n);
            running_d = 1'b1;
        end
        ready_d = ~pend_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= DivWidth'(DefaultDiv);
            div_pend_q <= DivWidth'(DefaultDiv);
            tail_q     <= '0;
            pend_q     <= 1'b0;
            clk_q      <= '0;
            start_q    <= 1'b0;
            running_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            tail_q     <= tail_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            start_q    <= start_d;
            running_q  <= running_d;
            ready_q    <= ready_d;
        end
    end

    assign clk0_o             = clk_q[0];
    assign clk90_o            = clk_q[1];
    assign clk180_o           = clk_q[2];
    assign clk270_o           = clk_q[3];
    assign period_start_o     = start_q;
    assign running_o          = running_q;
    assign div_o              = div_q;
    assign cfg_if.cfg_ready_o = ready_q;
endmodule

// File: tb/tb_hyper_clk_phase_gen.sv
// Self-checking bench for hyper_clk_phase_gen: directed table, corner sequences and
// randomized traffic against a segment-queue reference model.
module tb_hyper_clk_phase_gen;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic c0;
        logic c90;
        logic c180;
        logic c270;
        logic ps;
        logic run;
    } ovec_t;

    typedef struct {
        logic       en;
        logic [6:0] exp;   // {ready, c0, c90, c180, c270, period_start, running}
    } tvec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          c0, c90, c180, c270, ps, run;
    logic [DW-1:0] div;

    hyper_clk_phase_gen_if #(.DivWidth(DW)) cfg_if ();

    hyper_clk_phase_gen #(.DivWidth(DW), .DefaultDiv(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .cfg_if         (cfg_if),
        .clk0_o         (c0),
        .clk90_o        (c90),
        .clk180_o       (c180),
        .clk270_o       (c270),
        .running_o      (run),
        .period_start_o (ps),
        .div_o          (div)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each run period / drain is expanded into a queue of
    // expected output vectors straight from the waveform definition.
    ovec_t seg_q[$];
    int    m_mode;     // 0 idle, 1 run, 2 drain
    int    m_d;
    int    m_pend;
    int    m_pendv;
    ovec_t exp_o;
    int    exp_div;
    logic  exp_rdy;

    logic [3:0] mon_prev;
    logic [3:0] mon_seen;
    int         mon_w[4];
    logic       mon_on = 1'b0;
    int         n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        seg_q.delete();
        m_mode  = 0;
        m_d     = 1;
        m_pend  = 0;
        m_pendv = 0;
        exp_o   = '0;
        exp_div = 1;
        exp_rdy = 1'b1;
    endtask

    task automatic push_run(input int d, input int tail);
        for (int c = 0; c < 4 * d; c++) begin
            ovec_t v;
            v.c0   = (c < 2 * d);
            v.c90  = (c >= d) && (c < 3 * d);
            v.c180 = (c >= 2 * d);
            v.c270 = (c >= 3 * d) || (c < tail);
            v.ps   = (c == 0);
            v.run  = 1'b1;
            seg_q.push_back(v);
        end
    endtask

    task automatic push_drain(input int d);
        for (int c = 0; c < d; c++) begin
            ovec_t v;
            v      = '0;
            v.c270 = 1'b1;
            v.run  = 1'b1;
            seg_q.push_back(v);
        end
    endtask

    task automatic model_step(input logic e, input logic v, input int dv);
        int pend_old;
        int d_old;
        pend_old = m_pend;
        if (seg_q.size() == 0) begin
            case (m_mode)
                0: begin
                    if (m_pend != 0) begin
                        m_d    = m_pendv;
                        m_pend = 0;
                    end
                    if (e) begin
                        push_run(m_d, 0);
                        m_mode = 1;
                    end
                end
                1: begin
                    d_old = m_d;
                    if (e) begin
                        if (m_pend != 0) begin
                            m_d    = m_pendv;
                            m_pend = 0;
                        end
                        push_run(m_d, d_old);
                    end else begin
                        push_drain(m_d);
                        m_mode = 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
        exp_o = (seg_q.size() != 0) ? seg_q.pop_front() : '0;
        if (v && pend_old == 0) begin
            m_pend  = 1;
            m_pendv = (dv == 0) ? 1 : dv;
        end
        exp_div = m_d;
        exp_rdy = (m_pend == 0);
    endtask

    function automatic ovec_t act_vec();
        return ovec_t'({c0, c90, c180, c270, ps, run});
    endfunction

    task automatic mon_start();
        mon_on   = 1'b1;
        mon_prev = {c0, c90, c180, c270};
        mon_seen = '0;
        for (int i = 0; i < 4; i++) mon_w[i] = 0;
    endtask

    // Every observed complete pulse must be 2D high for D in {2,5}.
    task automatic mon_step();
        logic [3:0] cur;
        cur = {c0, c90, c180, c270};
        for (int i = 0; i < 4; i++) begin
            if (cur[i]) begin
                if (!mon_prev[i]) begin
                    mon_seen[i] = 1'b1;
                    mon_w[i]    = 1;
                end else begin
                    mon_w[i]++;
                end
            end else if (mon_prev[i] && mon_seen[i]) begin
                n_pulses++;
                check("pulse_width", 32'((mon_w[i] == 4 || mon_w[i] == 10) ? 1 : mon_w[i]), 32'd1);
            end
        end
        mon_prev = cur;
    endtask

    task automatic cyc(input logic e, input logic v, input int dv);
        en                 = e;
        cfg_if.cfg_valid_i = v;
        cfg_if.cfg_div_i   = DW'(dv);
        @(posedge clk);
        model_step(e, v, dv);
        @(negedge clk);
        check("cycle", 32'({cfg_if.cfg_ready_o, act_vec(), div}),
              32'({exp_rdy, exp_o, DW'(exp_div)}));
        if (mon_on) mon_step();
    endtask

    task automatic run_to_start();
        int guard;
        guard = 0;
        cyc(1'b1, 1'b0, 0);
        while (!exp_o.ps && guard < 100) begin
            cyc(1'b1, 1'b0, 0);
            guard++;
        end
        if (guard >= 100) check("wait_period_start", 32'd0, 32'd1);
    endtask

    tvec_t tbl[11];

    initial begin
        logic e_r;
        // D=1 start from reset, then stop with drain.
        tbl[0]  = '{en: 1'b1, exp: 7'b1_100011};
        tbl[1]  = '{en: 1'b1, exp: 7'b1_110001};
        tbl[2]  = '{en: 1'b1, exp: 7'b1_011001};
        tbl[3]  = '{en: 1'b1, exp: 7'b1_001101};
        tbl[4]  = '{en: 1'b1, exp: 7'b1_100111};
        tbl[5]  = '{en: 1'b1, exp: 7'b1_110001};
        tbl[6]  = '{en: 1'b1, exp: 7'b1_011001};
        tbl[7]  = '{en: 1'b1, exp: 7'b1_001101};
        tbl[8]  = '{en: 1'b0, exp: 7'b1_000101};
        tbl[9]  = '{en: 1'b0, exp: 7'b1_000000};
        tbl[10] = '{en: 1'b0, exp: 7'b1_000000};

        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_div_i   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_values", 32'({cfg_if.cfg_ready_o, act_vec(), div}), 32'({1'b1, 6'b0, 8'd1}));
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].en, 1'b0, 0);
            check("table", 32'({cfg_if.cfg_ready_o, act_vec()}), 32'(tbl[i].exp));
        end

        // D=3 configured in IDLE, then run and stop.
        cyc(1'b0, 1'b1, 3);
        cyc(1'b0, 1'b0, 0);
        check("div_after_idle_cfg", 32'(div), 32'd3);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 0);

        // D=2 running, D=5 accepted at cnt=1; pulse widths stay 4 or 10.
        cyc(1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 0);
        run_to_start();
        cyc(1'b1, 1'b0, 0);
        mon_start();
        cyc(1'b1, 1'b1, 5);
        check("ready_low_after_accept", 32'(cfg_if.cfg_ready_o), 32'd0);
        for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 0);
        mon_on = 1'b0;
        check("pulses_seen", 32'(n_pulses >= 8), 32'd1);

        // D=2 running, en dropped at cnt=3: finish period, drain 2, idle.
        cyc(1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 0);
        run_to_start();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 0);
        check("idle_after_drain", 32'({act_vec()}), 32'd0);

        // cfg_div=0 becomes 1; back-to-back valid while pending is not taken.
        cyc(1'b0, 1'b1, 0);
        cyc(1'b0, 1'b1, 7);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0);
        check("div_zero_as_one", 32'(div), 32'd1);

        // Asynchronous reset at cnt=5 with D=3.
        cyc(1'b0, 1'b1, 3);
        cyc(1'b0, 1'b0, 0);
        run_to_start();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({cfg_if.cfg_ready_o, act_vec(), div}), 32'({1'b1, 6'b0, 8'd1}));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0);

        // Randomized traffic.
        e_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) e_r = ~e_r;
            cyc(e_r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hyper_clk_phase_gen.md
Name: hyper_clk_phase_gen

Overview:
- Programmable successor to the fixed 4-phase clock generator.
- Divides the fast clock clk_i by 4*D (D = runtime divide setting) and produces four 50%-duty clocks at 0/90/180/270 degrees, offset by D input cycles each.
- Supports a glitch-free divider change through a valid/ready config handshake, and a clean start/stop through en_i.
- Sits between the system clock and the HyperBus PHY; uses posedge clk_i logic only, with all outputs driven directly from flops.

Parameters:
- DivWidth, 8, width of the divide setting D.
- DefaultDiv, 1, D value loaded at reset (1..2^DivWidth-1).

Ports:
- clk_i  in  1  fast input clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  run request (level)
- cfg_valid_i  in  1  new divide setting offered
- cfg_ready_o  out  1  new setting can be accepted
- cfg_div_i  in  DivWidth  requested D; 0 treated as 1
- clk0_o  out  1  0-degree output clock
- clk90_o  out  1  90-degree output clock
- clk180_o  out  1  180-degree output clock
- clk270_o  out  1  270-degree output clock
- running_o  out  1  generator active (RUN or DRAIN)
- period_start_o  out  1  one-cycle pulse while cnt_q==0 in RUN
- div_o  out  DivWidth  D currently in effect

Behaviour:
- Reset: asynchronous, active-low; the clock is clk_i.
- Reset values:
  - state=IDLE, cnt_q=0, div_q=DefaultDiv, pending=0.
  - All clk*_o=0, running_o=0, period_start_o=0, cfg_ready_o=1.
- Counter:
  - cnt_q has width DivWidth+2 and counts 0..4*div_q-1, then wraps to 0.
- Output waveform, in RUN, as a function of cnt_q in the same cycle (registered from next-state values, no combinational path from cnt_q):
  - clk0_o=1 for cnt in [0,2D).
  - clk90_o=1 for cnt in [D,3D).
  - clk180_o=1 for cnt in [2D,4D).
  - clk270_o=1 for cnt in [3D,4D) or [0,D).
- States:
  - IDLE: cnt_q=0 and all clocks low. If en_i=1: next state RUN with cnt_q=0.
  - RUN: cnt_q increments every cycle. If en_i=0 when cnt_q==4D-1: next state DRAIN with cnt_q=0. Otherwise cnt_q wraps and RUN continues. Deasserting en_i mid-period has no effect until the period boundary.
  - DRAIN: cnt_q counts 0..D-1.
    - clk0_o and clk90_o are forced 0.
    - clk270_o follows the waveform, completing its final high pulse; clk180_o is 0.
    - At cnt_q==D-1: next state IDLE, all clocks 0.
    - en_i is ignored in DRAIN; a restart waits for IDLE.
- Pulse integrity: every output pulse is exactly 2D cycles high. The first pulse after start and the last pulse before stop are never truncated. On start, clk270_o stays low for cnt in [0,D) of the first period.
- Config handshake:
  - Transfer occurs when cfg_valid_i & cfg_ready_o. It stores max(cfg_div_i,1) into div_pend and sets pending=1.
  - cfg_ready_o = ~pending.
  - Apply rules:
    - In IDLE: applied on the next cycle.
    - In RUN: applied only on the wrap cycle (cnt_q==4D-1 → 0), so the next period uses the new D.
    - In DRAIN: held until IDLE.
  - On apply: div_q<=div_pend, pending<=0.
  - A transfer on the same cycle as an apply of a previous value is impossible, since ready=0 while pending.
- running_o: 1 in RUN and DRAIN.
- div_o = div_q.
- Reset mid-operation: all state returns to reset values immediately (async); clocks drop to 0. A glitch here is acceptable, being reset-only.
- D=1 special case: the waveform equals the 4-cycle quadrature pattern (period 4 input cycles).

Test Plan:
- Reset with en_i=1, D=1 → after release, clk0 pattern 1100, clk90 0110, clk180 0011, clk270 first 0 then 1001 repeating; period_start_o every 4 cycles.
- cfg_div_i=3 written in IDLE, then en_i=1 → period 12 cycles, each output high 6 cycles; clk90 rises 3 cycles after clk0; div_o=3.
- Running D=2, cfg_div_i=5 accepted at cnt_q=1 → cfg_ready_o low until wrap at cnt_q=7; next period is 20 cycles; no pulse other than 4 or 10 cycles high.
- Running D=2, en_i dropped at cnt_q=3 → period completes to cnt_q=7, DRAIN 2 cycles with only clk270 high, then IDLE with all 0 and running_o=0.
- cfg_div_i=0 accepted → div_o=1; second cfg_valid_i while pending sees cfg_ready_o=0 and is not taken.
- rst_ni asserted at cnt_q=5 with D=3 → all outputs 0 that cycle; after release, div_o=DefaultDiv and state IDLE until en_i.
